// File: rtl/ddr3_cont_req_queue.sv
// CPU-side request queue for the DDR3 controller: captures CPU requests into a
// FIFO and presents them first-word-fall-through to the controller core.
module ddr3_cont_req_queue #(
    parameter int DEPTH  = 8,
    parameter int SKID   = 1,
    parameter int ADDR_W = 15,
    parameter int BA_W   = 3,
    parameter int COL_W  = 10,
    parameter int DATA_W = 64
) (
    input  logic                         cpu_clk,
    input  logic                         reset_n,
    input  logic                         cpu_addr_valid,
    input  logic                         cpu_cmd,
    input  logic [BA_W-1:0]              cpu_ba,
    input  logic [ADDR_W-1:0]            cpu_addr,
    input  logic [COL_W-1:0]             cpu_col,
    input  logic [DATA_W-1:0]            cpu_wr_data,
    output logic                         cpu_cmd_rdy,
    output logic                         req_valid,
    input  logic                         req_ready,
    output logic                         req_cmd,
    output logic [BA_W-1:0]              req_ba,
    output logic [ADDR_W-1:0]            req_addr,
    output logic [COL_W-1:0]             req_col,
    output logic [DATA_W-1:0]            req_wr_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    input  logic                         ovf_clr,
    output logic                         ovf_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENT_W = 1 + BA_W + ADDR_W + COL_W + DATA_W;

    logic [ENT_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;

    logic             push;
    logic             pop;
    logic             drop;
    logic [ENT_W-1:0] wr_entry;
    logic [ENT_W-1:0] rd_entry;

    assign wr_entry = {cpu_cmd, cpu_ba, cpu_addr, cpu_col, cpu_wr_data};
    assign rd_entry = mem[rd_ptr_q];

    // Full/empty come from the occupancy counter alone; pointers just wrap.
    assign pop  = (count_q != '0) && req_ready;
    assign push = cpu_addr_valid && ((count_q < CNT_W'(DEPTH)) || pop);
    assign drop = cpu_addr_valid && !push;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // A drop in the same cycle as a clear must still be reported.
        if (drop)         ovf_d = 1'b1;
        else if (ovf_clr) ovf_d = 1'b0;
    end

    always_ff @(posedge cpu_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (push) mem[wr_ptr_q] <= wr_entry;
    end

    // Ready drops SKID entries early so the CPU's registered valid still fits.
    assign cpu_cmd_rdy = reset_n && (count_q <= CNT_W'(DEPTH - 1 - SKID));
    assign req_valid   = (count_q != '0);
    assign count       = count_q;
    assign ovf_err     = ovf_q;
    assign {req_cmd, req_ba, req_addr, req_col, req_wr_data} = rd_entry;

endmodule

// File: tb/tb_ddr3_cont_req_queue.sv
// Randomized bench for ddr3_cont_req_queue against a queue-based reference model.
module tb_ddr3_cont_req_queue;

    localparam int DEPTH = 8;
    localparam int SKID  = 1;

    typedef struct packed {
        logic        cmd;
        logic [2:0]  ba;
        logic [14:0] addr;
        logic [9:0]  col;
        logic [63:0] data;
    } ent_t;

    logic        cpu_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_addr_valid = 1'b0;
    logic        cpu_cmd = 1'b0;
    logic [2:0]  cpu_ba = '0;
    logic [14:0] cpu_addr = '0;
    logic [9:0]  cpu_col = '0;
    logic [63:0] cpu_wr_data = '0;
    logic        cpu_cmd_rdy;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic        req_cmd;
    logic [2:0]  req_ba;
    logic [14:0] req_addr;
    logic [9:0]  req_col;
    logic [63:0] req_wr_data;
    logic [3:0]  count;
    logic        ovf_clr = 1'b0;
    logic        ovf_err;

    ddr3_cont_req_queue #(
        .DEPTH(DEPTH), .SKID(SKID), .ADDR_W(15), .BA_W(3), .COL_W(10), .DATA_W(64)
    ) dut (
        .cpu_clk(cpu_clk), .reset_n(reset_n), .cpu_addr_valid(cpu_addr_valid),
        .cpu_cmd(cpu_cmd), .cpu_ba(cpu_ba), .cpu_addr(cpu_addr), .cpu_col(cpu_col),
        .cpu_wr_data(cpu_wr_data), .cpu_cmd_rdy(cpu_cmd_rdy), .req_valid(req_valid),
        .req_ready(req_ready), .req_cmd(req_cmd), .req_ba(req_ba), .req_addr(req_addr),
        .req_col(req_col), .req_wr_data(req_wr_data), .count(count),
        .ovf_clr(ovf_clr), .ovf_err(ovf_err)
    );

    always #5 cpu_clk = ~cpu_clk;

    int   checks = 0;
    int   errors = 0;
    ent_t model_q[$];
    bit   model_ovf = 1'b0;
    bit   last_push;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Compare all outputs against the model, clock once, then advance the model.
    task automatic do_cycle(input bit v, input ent_t e, input bit rdy, input bit clr);
        bit do_pop, do_push, do_drop;
        cpu_addr_valid = v;
        {cpu_cmd, cpu_ba, cpu_addr, cpu_col, cpu_wr_data} = e;
        req_ready = rdy;
        ovf_clr   = clr;
        #1;
        check("count", 64'(count), 64'(model_q.size()));
        check("req_valid", 64'(req_valid), 64'(model_q.size() != 0));
        check("cmd_rdy", 64'(cpu_cmd_rdy), 64'(model_q.size() <= DEPTH - 1 - SKID));
        check("ovf_err", 64'(ovf_err), 64'(model_ovf));
        if (model_q.size() != 0) begin
            check("head", 64'({req_cmd, req_ba, req_addr, req_col}), 64'({model_q[0].cmd, model_q[0].ba, model_q[0].addr, model_q[0].col}));
            check("head_data", req_wr_data, model_q[0].data);
        end
        @(posedge cpu_clk);
        do_pop  = (model_q.size() != 0) && rdy;
        do_push = v && (model_q.size() < DEPTH || do_pop);
        do_drop = v && !do_push;
        if (do_pop) void'(model_q.pop_front());
        if (do_push) model_q.push_back(e);
        if (do_drop) model_ovf = 1'b1;
        else if (clr) model_ovf = 1'b0;
        last_push = do_push;
        $display("cyc v=%0b rdy=%0b clr=%0b push=%0b pop=%0b drop=%0b occ=%0d", v, rdy, clr, do_push, do_pop, do_drop, model_q.size());
        @(negedge cpu_clk);
    endtask

    function automatic ent_t rand_ent(input int tag);
        ent_t e;
        e.cmd  = 1'($urandom);
        e.ba   = 3'($urandom);
        e.addr = 15'(tag * 311 + 7);
        e.col  = 10'($urandom);
        e.data = {$urandom, $urandom};
        return e;
    endfunction

    initial begin
        ent_t e;
        ent_t idle;
        bit   vreg;
        int   pushed;
        int   cyc;

        idle = '0;
        @(negedge cpu_clk);
        @(negedge cpu_clk);
        #1;
        check("rst_valid", 64'(req_valid), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_rdy", 64'(cpu_cmd_rdy), 64'd0);
        check("rst_ovf", 64'(ovf_err), 64'd0);
        @(negedge cpu_clk);
        reset_n = 1'b1;

        // Single directed write request.
        e = '{cmd: 1'b1, ba: 3'h5, addr: 15'h1234, col: 10'h2A, data: 64'hDEADBEEF_CAFEF00D};
        do_cycle(1'b1, e, 1'b0, 1'b0);
        #1;
        check("t1_valid", 64'(req_valid), 64'd1);
        check("t1_addr", 64'(req_addr), 64'h1234);
        check("t1_data", req_wr_data, 64'hDEADBEEF_CAFEF00D);
        check("t1_count", 64'(count), 64'd1);
        do_cycle(1'b0, idle, 1'b1, 1'b0);

        // CPU model registers its valid from cmd_rdy.
        vreg = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bit r;
            r = cpu_cmd_rdy;
            do_cycle(vreg, rand_ent(100 + i), 1'b0, 1'b0);
            vreg = r;
        end
        check("skid_count", 64'(count), 64'd8);
        check("skid_ovf", 64'(ovf_err), 64'd0);

        // Drop at full, then clear; then drop and clear together.
        do_cycle(1'b1, rand_ent(200), 1'b0, 1'b0);
        check("drop_ovf", 64'(ovf_err), 64'd1);
        do_cycle(1'b0, idle, 1'b0, 1'b1);
        check("clr_ovf", 64'(ovf_err), 64'd0);
        do_cycle(1'b1, rand_ent(201), 1'b0, 1'b1);
        check("set_wins", 64'(ovf_err), 64'd1);
        do_cycle(1'b0, idle, 1'b0, 1'b1);

        // Push and pop together at full.
        do_cycle(1'b1, rand_ent(300), 1'b1, 1'b0);
        check("full_pp_count", 64'(count), 64'd8);
        check("full_pp_ovf", 64'(ovf_err), 64'd0);

        // Drain.
        for (int i = 0; i < DEPTH; i++) do_cycle(1'b0, idle, 1'b1, 1'b0);

        // Randomized 20-request stream.
        pushed = 0;
        cyc = 0;
        while ((pushed < 20 || model_q.size() != 0) && cyc < 500) begin
            bit v;
            v = (pushed < 20) && ($urandom_range(0, 3) != 0) && (model_q.size() < DEPTH);
            do_cycle(v, rand_ent(400 + pushed), 1'($urandom), 1'b0);
            if (last_push) pushed++;
            cyc++;
        end
        check("stream_timeout", 64'(cyc < 500), 64'd1);
        check("stream_empty", 64'(count), 64'd0);

        // Reset mid-operation with five entries queued.
        for (int i = 0; i < 5; i++) do_cycle(1'b1, rand_ent(600 + i), 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_valid", 64'(req_valid), 64'd0);
        check("arst_count", 64'(count), 64'd0);
        check("arst_rdy", 64'(cpu_cmd_rdy), 64'd0);
        model_q.delete();
        model_ovf = 1'b0;
        @(negedge cpu_clk);
        reset_n = 1'b1;
        e = rand_ent(700);
        do_cycle(1'b1, e, 1'b0, 1'b0);
        #1;
        check("post_rst_addr", 64'(req_addr), 64'(e.addr));
        check("post_rst_data", req_wr_data, e.data);
        do_cycle(1'b0, idle, 1'b1, 1'b0);
        do_cycle(1'b0, idle, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
